// File: rtl/cpu_switch_sequencer_if.sv
// Signal bundle between the S1990 register file, the two T80a cores and the
// slot-bus hand-over sequencer.
interface cpu_switch_sequencer_if;
    logic sel_r800;
    logic step_execute_en;
    logic step_execute;
    logic n_z80_m1;
    logic n_r800_m1;
    logic n_z80_busack;
    logic n_r800_busack;
    logic n_z80_busrq;
    logic n_r800_busrq;
    logic processor_mode;
    logic busy;
    logic timeout_err;

    // The register file and the cores drive requests and core status.
    modport master (
        output sel_r800, step_execute_en, step_execute,
        output n_z80_m1, n_r800_m1, n_z80_busack, n_r800_busack,
        input  n_z80_busrq, n_r800_busrq, processor_mode, busy, timeout_err
    );

    // The sequencer owns the bus-request pins and the mode steering.
    modport slave (
        input  sel_r800, step_execute_en, step_execute,
        input  n_z80_m1, n_r800_m1, n_z80_busack, n_r800_busack,
        output n_z80_busrq, n_r800_busrq, processor_mode, busy, timeout_err
    );
endinterface

// File: rtl/cpu_switch_sequencer.sv
// Hands the MSX slot bus between the Z80 and R800 cores via BUSRQ_n/BUSAK_n and
// provides single-step execution (one M1 cycle per step pulse) for debug.
module cpu_switch_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         RESET_n,
    cpu_switch_sequencer_if.slave        bus
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_HOLD      = 3'd1,
        ST_SWAP      = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_STEP_IDLE = 3'd4,
        ST_STEP_RUN  = 3'd5
    } state_t;

    state_t     state_q;
    logic       purpose_swap_q;
    logic       want_q;
    logic       mode_q;
    logic       z80_rq_q;
    logic       r800_rq_q;
    logic       busy_q;
    logic       err_q;
    logic       err_sel_q;
    logic       err_en_q;
    logic       z80_ack_q;
    logic       r800_ack_q;
    logic       z80_m1_q;
    logic       r800_m1_q;
    logic       act_m1_prev_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    logic want_s;
    logic act_ack_s;
    logic act_m1_s;
    logic m1_fall_s;
    logic changed_s;
    logic retry_ok_s;
    logic timeout_s;

    // BUSRQ_n pair {z80, r800}: the inactive core is always held; the active
    // core is released only when act_free is set.
    function automatic logic [1:0] busrq_f(input logic mode, input logic act_free);
        logic [1:0] rq;
        if (mode) begin
            rq = {act_free, 1'b0};
        end else begin
            rq = {1'b0, act_free};
        end
        return rq;
    endfunction

    // Active-core views of the registered pins and request bookkeeping.
    always_comb begin
        want_s     = ~bus.sel_r800;
        act_ack_s  = mode_q ? z80_ack_q : r800_ack_q;
        act_m1_s   = mode_q ? z80_m1_q : r800_m1_q;
        m1_fall_s  = act_m1_prev_q & ~act_m1_s;
        cnt_d      = cnt_q + 8'd1;
        timeout_s  = (cnt_d == TIMEOUT_C);
        // After a timeout, requests stay blocked until the host changes a request input.
        changed_s  = (bus.sel_r800 != err_sel_q) | (bus.step_execute_en != err_en_q);
        retry_ok_s = ~err_q | changed_s;
    end

    // Input registers, hand-over / single-step FSM and its registered outputs.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q        <= ST_RUN;
            purpose_swap_q <= 1'b0;
            want_q         <= 1'b1;
            mode_q         <= 1'b1;
            z80_rq_q       <= 1'b1;
            r800_rq_q      <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
            err_sel_q      <= 1'b0;
            err_en_q       <= 1'b0;
            z80_ack_q      <= 1'b1;
            r800_ack_q     <= 1'b1;
            z80_m1_q       <= 1'b1;
            r800_m1_q      <= 1'b1;
            act_m1_prev_q  <= 1'b1;
            cnt_q          <= 8'd0;
        end else begin
            z80_ack_q     <= bus.n_z80_busack;
            r800_ack_q    <= bus.n_r800_busack;
            z80_m1_q      <= bus.n_z80_m1;
            r800_m1_q     <= bus.n_r800_m1;
            act_m1_prev_q <= act_m1_s;

            case (state_q)
                ST_RUN: begin
                    if (retry_ok_s && (want_s != mode_q)) begin
                        state_q                <= ST_HOLD;
                        purpose_swap_q         <= 1'b1;
                        want_q                 <= want_s;
                        cnt_q                  <= 8'd0;
                        err_q                  <= 1'b0;
                        busy_q                 <= 1'b1;
                        {z80_rq_q, r800_rq_q}  <= busrq_f(mode_q, 1'b0);
                    end else if (retry_ok_s && bus.step_execute_en) begin
                        state_q                <= ST_HOLD;
                        purpose_swap_q         <= 1'b0;
                        cnt_q                  <= 8'd0;
                        err_q                  <= 1'b0;
                        busy_q                 <= 1'b1;
                        {z80_rq_q, r800_rq_q}  <= busrq_f(mode_q, 1'b0);
                    end else begin
                        state_q                <= ST_RUN;
                        err_q                  <= err_q & ~changed_s;
                        busy_q                 <= 1'b0;
                        {z80_rq_q, r800_rq_q}  <= busrq_f(mode_q, 1'b1);
                    end
                end

                ST_HOLD: begin
                    if (!act_ack_s) begin
                        cnt_q <= 8'd0;
                        if (purpose_swap_q) begin
                            state_q               <= ST_SWAP;
                            busy_q                <= 1'b1;
                            {z80_rq_q, r800_rq_q} <= 2'b00;
                        end else begin
                            state_q               <= ST_STEP_IDLE;
                            busy_q                <= 1'b0;
                            {z80_rq_q, r800_rq_q} <= busrq_f(mode_q, 1'b0);
                        end
                    end else if (timeout_s) begin
                        state_q               <= ST_RUN;
                        err_q                 <= 1'b1;
                        err_sel_q             <= bus.sel_r800;
                        err_en_q              <= bus.step_execute_en;
                        busy_q                <= 1'b0;
                        {z80_rq_q, r800_rq_q} <= busrq_f(mode_q, 1'b1);
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                // Mode flips on the same edge the incoming core is released,
                // so the two BUSRQ_n pins are never high together.
                ST_SWAP: begin
                    state_q               <= ST_RELEASE;
                    mode_q                <= want_q;
                    cnt_q                 <= 8'd0;
                    busy_q                <= 1'b1;
                    {z80_rq_q, r800_rq_q} <= busrq_f(want_q, 1'b1);
                end

                ST_RELEASE: begin
                    if (act_ack_s) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end else if (timeout_s) begin
                        state_q   <= ST_RUN;
                        err_q     <= 1'b1;
                        err_sel_q <= bus.sel_r800;
                        err_en_q  <= bus.step_execute_en;
                        busy_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                ST_STEP_IDLE: begin
                    if (want_s != mode_q) begin
                        state_q               <= ST_SWAP;
                        want_q                <= want_s;
                        busy_q                <= 1'b1;
                        {z80_rq_q, r800_rq_q} <= 2'b00;
                    end else if (bus.step_execute) begin
                        state_q               <= ST_STEP_RUN;
                        busy_q                <= 1'b1;
                        {z80_rq_q, r800_rq_q} <= busrq_f(mode_q, 1'b1);
                    end else if (!bus.step_execute_en) begin
                        state_q               <= ST_RUN;
                        busy_q                <= 1'b0;
                        {z80_rq_q, r800_rq_q} <= busrq_f(mode_q, 1'b1);
                    end else begin
                        state_q <= ST_STEP_IDLE;
                    end
                end

                // Re-request the bus as soon as the first opcode fetch is seen;
                // the core finishes that instruction before acknowledging.
                ST_STEP_RUN: begin
                    if (m1_fall_s) begin
                        state_q               <= ST_HOLD;
                        purpose_swap_q        <= 1'b0;
                        cnt_q                 <= 8'd0;
                        busy_q                <= 1'b1;
                        {z80_rq_q, r800_rq_q} <= busrq_f(mode_q, 1'b0);
                    end else begin
                        state_q <= ST_STEP_RUN;
                    end
                end

                default: begin
                    state_q               <= ST_RUN;
                    cnt_q                 <= 8'd0;
                    busy_q                <= 1'b0;
                    {z80_rq_q, r800_rq_q} <= busrq_f(mode_q, 1'b1);
                end
            endcase
        end
    end

    assign bus.n_z80_busrq    = z80_rq_q;
    assign bus.n_r800_busrq   = r800_rq_q;
    assign bus.processor_mode = mode_q;
    assign bus.busy           = busy_q;
    assign bus.timeout_err    = err_q;

endmodule

// File: tb/tb_cpu_switch_sequencer.sv
// Bench for cpu_switch_sequencer: behavioural Z80/R800 cores (delayed BUSAK_n,
// NOP stream on M1_n) with scoreboards for final processor mode and M1 counts.
module tb_cpu_switch_sequencer;

    logic clk = 1'b0;
    logic RESET_n;
    int   total = 0;
    int   bad = 0;
    int   both_high = 0;

    logic ack_pin [2];
    logic m1_pin [2];
    bit   ack_en [2];
    int   ack_dly [2];
    int   ack_cnt [2];
    int   m1_ph [2];
    int   m1_cnt [2];

    logic exp_mode_q [$];
    int   exp_m1_q [$];

    cpu_switch_sequencer_if bus();

    cpu_switch_sequencer #(.TIMEOUT(16)) dut (
        .clk     (clk),
        .RESET_n (RESET_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // One clock: sample just after the edge, then update both core models (index 0 = Z80).
    task automatic tick();
        logic rq [2];
        @(posedge clk);
        #1;
        rq[0] = bus.n_z80_busrq;
        rq[1] = bus.n_r800_busrq;
        if (rq[0] === 1'b1 && rq[1] === 1'b1) both_high++;
        for (int c = 0; c < 2; c++) begin
            if (rq[c] === 1'b1) begin
                ack_cnt[c] = 0;
                ack_pin[c] = 1'b1;
                m1_pin[c]  = (m1_ph[c] == 0) ? 1'b0 : 1'b1;
                if (m1_ph[c] == 0) m1_cnt[c]++;
                m1_ph[c] = (m1_ph[c] + 1) % 4;
            end else begin
                m1_pin[c] = 1'b1;
                m1_ph[c]  = 0;
                if (ack_en[c] && ack_cnt[c] < ack_dly[c]) ack_cnt[c]++;
                if (ack_en[c] && ack_cnt[c] >= ack_dly[c]) ack_pin[c] = 1'b0;
            end
        end
        bus.n_z80_busack  = ack_pin[0];
        bus.n_r800_busack = ack_pin[1];
        bus.n_z80_m1      = m1_pin[0];
        bus.n_r800_m1     = m1_pin[1];
    endtask

    task automatic test_reset();
        RESET_n = 1'b0;
        repeat (3) tick();
        total++; if (bus.processor_mode !== 1'b1) begin bad++; $display("FAIL reset_mode: got %b want 1", bus.processor_mode); end
        total++; if (bus.n_z80_busrq !== 1'b1) begin bad++; $display("FAIL reset_z80_busrq: got %b want 1", bus.n_z80_busrq); end
        total++; if (bus.n_r800_busrq !== 1'b0) begin bad++; $display("FAIL reset_r800_busrq: got %b want 0", bus.n_r800_busrq); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.timeout_err); end
        RESET_n = 1'b1;
        repeat (8) tick();
        total++; if (bus.busy !== 1'b0 || bus.n_z80_busrq !== 1'b1) begin bad++; $display("FAIL reset_idle: busy=%b z80_busrq=%b want 0/1", bus.busy, bus.n_z80_busrq); end
    endtask

    task automatic test_swap_to_r800();
        int   n;
        logic e;
        ack_dly[0] = 5;
        both_high  = 0;
        exp_mode_q.push_back(1'b0);
        bus.sel_r800 = 1'b1;
        tick();
        total++; if (bus.n_z80_busrq !== 1'b0) begin bad++; $display("FAIL swap_rq_low: n_z80_busrq=%b want 0", bus.n_z80_busrq); end
        n = 0;
        while (bus.n_z80_busack !== 1'b0 && n < 20) begin tick(); n++; end
        total++; if (n >= 20) begin bad++; $display("FAIL swap_ack_wait: no z80 busack after %0d clk", n); end
        tick();
        tick();
        total++; if (bus.processor_mode !== 1'b1 || bus.n_r800_busrq !== 1'b0 || bus.n_z80_busrq !== 1'b0) begin
            bad++; $display("FAIL swap_state: mode=%b z80_rq=%b r800_rq=%b want 1/0/0", bus.processor_mode, bus.n_z80_busrq, bus.n_r800_busrq);
        end
        tick();
        total++; if (bus.processor_mode !== 1'b0 || bus.n_r800_busrq !== 1'b1 || bus.n_z80_busrq !== 1'b0) begin
            bad++; $display("FAIL swap_flip: mode=%b z80_rq=%b r800_rq=%b want 0/0/1", bus.processor_mode, bus.n_z80_busrq, bus.n_r800_busrq);
        end
        tick();
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL swap_release_busy: got %b want 1", bus.busy); end
        tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL swap_done_busy: got %b want 0", bus.busy); end
        e = exp_mode_q.pop_front();
        total++; if (bus.processor_mode !== e) begin bad++; $display("FAIL swap_mode: got %b want %b", bus.processor_mode, e); end
        total++; if (both_high != 0) begin bad++; $display("FAIL swap_both_high: got %0d cycles want 0", both_high); end
    endtask

    task automatic test_swap_back_toggle();
        int   n;
        logic e;
        ack_dly[1] = 3;
        both_high  = 0;
        exp_mode_q.push_back(1'b1);
        exp_mode_q.push_back(1'b0);
        bus.sel_r800 = 1'b0;
        tick();
        total++; if (bus.n_r800_busrq !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL back_hold: r800_rq=%b busy=%b want 0/1", bus.n_r800_busrq, bus.busy); end
        tick();
        bus.sel_r800 = 1'b1;
        n = 0;
        while (bus.busy !== 1'b0 && n < 30) begin tick(); n++; end
        total++; if (n >= 30) begin bad++; $display("FAIL back_wait1: busy stuck after %0d clk", n); end
        e = exp_mode_q.pop_front();
        total++; if (bus.processor_mode !== e) begin bad++; $display("FAIL back_mode1: got %b want %b", bus.processor_mode, e); end
        total++; if (bus.n_z80_busrq !== 1'b1) begin bad++; $display("FAIL back_z80_free: got %b want 1", bus.n_z80_busrq); end
        tick();
        total++; if (bus.busy !== 1'b1 || bus.n_z80_busrq !== 1'b0) begin bad++; $display("FAIL back_reverse_start: busy=%b z80_rq=%b want 1/0", bus.busy, bus.n_z80_busrq); end
        n = 0;
        while (bus.busy !== 1'b0 && n < 30) begin tick(); n++; end
        total++; if (n >= 30) begin bad++; $display("FAIL back_wait2: busy stuck after %0d clk", n); end
        e = exp_mode_q.pop_front();
        total++; if (bus.processor_mode !== e) begin bad++; $display("FAIL back_mode2: got %b want %b", bus.processor_mode, e); end
        total++; if (both_high != 0) begin bad++; $display("FAIL back_both_high: got %0d cycles want 0", both_high); end
    endtask

    task automatic test_timeout();
        int   n;
        logic e;
        ack_en[1] = 1'b0;
        bus.sel_r800 = 1'b0;
        tick();
        total++; if (bus.n_r800_busrq !== 1'b0) begin bad++; $display("FAIL to_hold: r800_rq=%b want 0", bus.n_r800_busrq); end
        repeat (15) tick();
        total++; if (bus.timeout_err !== 1'b0 || bus.n_r800_busrq !== 1'b0) begin bad++; $display("FAIL to_early: err=%b r800_rq=%b want 0/0", bus.timeout_err, bus.n_r800_busrq); end
        tick();
        total++; if (bus.timeout_err !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", bus.timeout_err); end
        total++; if (bus.n_r800_busrq !== 1'b1 || bus.processor_mode !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL to_release: r800_rq=%b mode=%b busy=%b want 1/0/0", bus.n_r800_busrq, bus.processor_mode, bus.busy);
        end
        repeat (5) tick();
        total++; if (bus.timeout_err !== 1'b1 || bus.busy !== 1'b0 || bus.n_r800_busrq !== 1'b1) begin
            bad++; $display("FAIL to_no_retry: err=%b busy=%b r800_rq=%b want 1/0/1", bus.timeout_err, bus.busy, bus.n_r800_busrq);
        end
        ack_en[1] = 1'b1;
        bus.sel_r800 = 1'b1;
        tick();
        total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL to_clear: err=%b want 0", bus.timeout_err); end
        exp_mode_q.push_back(1'b1);
        bus.sel_r800 = 1'b0;
        tick();
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL to_retry_start: busy=%b want 1", bus.busy); end
        n = 0;
        while (bus.busy !== 1'b0 && n < 30) begin tick(); n++; end
        total++; if (n >= 30) begin bad++; $display("FAIL to_retry_wait: busy stuck after %0d clk", n); end
        e = exp_mode_q.pop_front();
        total++; if (bus.processor_mode !== e) begin bad++; $display("FAIL to_retry_mode: got %b want %b", bus.processor_mode, e); end
    endtask

    task automatic test_step();
        int n;
        int base;
        int e;
        ack_dly[0] = 3;
        bus.step_execute_en = 1'b1;
        tick();
        total++; if (bus.busy !== 1'b1 || bus.n_z80_busrq !== 1'b0) begin bad++; $display("FAIL step_hold: busy=%b z80_rq=%b want 1/0", bus.busy, bus.n_z80_busrq); end
        n = 0;
        while (bus.busy !== 1'b0 && n < 20) begin tick(); n++; end
        total++; if (n >= 20) begin bad++; $display("FAIL step_idle_wait: busy stuck after %0d clk", n); end
        base = m1_cnt[0];
        repeat (6) tick();
        total++; if (m1_cnt[0] != base || bus.n_z80_busrq !== 1'b0) begin bad++; $display("FAIL step_held: m1=%0d z80_rq=%b want %0d/0", m1_cnt[0], bus.n_z80_busrq, base); end
        for (int s = 0; s < 3; s++) begin
            exp_m1_q.push_back(m1_cnt[0] + 1);
            bus.step_execute = 1'b1;
            tick();
            bus.step_execute = 1'b0;
            total++; if (bus.busy !== 1'b1 || bus.n_z80_busrq !== 1'b1) begin bad++; $display("FAIL step_go%0d: busy=%b z80_rq=%b want 1/1", s, bus.busy, bus.n_z80_busrq); end
            if (s == 1) begin
                n = 0;
                while (bus.n_z80_busrq !== 1'b0 && n < 20) begin tick(); n++; end
                total++; if (n >= 20) begin bad++; $display("FAIL step_rehold_wait: z80_rq stuck high after %0d clk", n); end
                bus.step_execute = 1'b1;
                tick();
                bus.step_execute = 1'b0;
            end
            n = 0;
            while (bus.busy !== 1'b0 && n < 30) begin tick(); n++; end
            total++; if (n >= 30) begin bad++; $display("FAIL step_done_wait%0d: busy stuck after %0d clk", s, n); end
            repeat (4) tick();
            e = exp_m1_q.pop_front();
            total++; if (m1_cnt[0] != e) begin bad++; $display("FAIL step_m1_count%0d: got %0d want %0d", s, m1_cnt[0], e); end
            total++; if (bus.n_z80_busrq !== 1'b0) begin bad++; $display("FAIL step_reheld%0d: z80_rq=%b want 0", s, bus.n_z80_busrq); end
        end
        bus.step_execute_en = 1'b0;
        tick();
        total++; if (bus.busy !== 1'b0 || bus.n_z80_busrq !== 1'b1) begin bad++; $display("FAIL step_exit: busy=%b z80_rq=%b want 0/1", bus.busy, bus.n_z80_busrq); end
        repeat (4) tick();
    endtask

    task automatic test_reset_in_swap();
        int n;
        ack_dly[0] = 2;
        bus.sel_r800 = 1'b1;
        tick();
        n = 0;
        while (bus.n_z80_busack !== 1'b0 && n < 20) begin tick(); n++; end
        total++; if (n >= 20) begin bad++; $display("FAIL rs_ack_wait: no z80 busack after %0d clk", n); end
        tick();
        tick();
        total++; if (bus.n_z80_busrq !== 1'b0 || bus.n_r800_busrq !== 1'b0 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL rs_in_swap: z80_rq=%b r800_rq=%b busy=%b want 0/0/1", bus.n_z80_busrq, bus.n_r800_busrq, bus.busy);
        end
        #2;
        RESET_n = 1'b0;
        #1;
        total++; if (bus.processor_mode !== 1'b1 || bus.n_z80_busrq !== 1'b1 || bus.n_r800_busrq !== 1'b0) begin
            bad++; $display("FAIL rs_async_outputs: mode=%b z80_rq=%b r800_rq=%b want 1/1/0", bus.processor_mode, bus.n_z80_busrq, bus.n_r800_busrq);
        end
        total++; if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) begin bad++; $display("FAIL rs_async_flags: busy=%b err=%b want 0/0", bus.busy, bus.timeout_err); end
        bus.sel_r800 = 1'b0;
        repeat (2) tick();
        RESET_n = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_n             = 1'b0;
        bus.sel_r800        = 1'b0;
        bus.step_execute_en = 1'b0;
        bus.step_execute    = 1'b0;
        bus.n_z80_m1        = 1'b1;
        bus.n_r800_m1       = 1'b1;
        bus.n_z80_busack    = 1'b1;
        bus.n_r800_busack   = 1'b1;
        for (int c = 0; c < 2; c++) begin
            ack_pin[c] = 1'b1;
            m1_pin[c]  = 1'b1;
            ack_en[c]  = 1'b1;
            ack_dly[c] = 4;
            ack_cnt[c] = 0;
            m1_ph[c]   = 0;
            m1_cnt[c]  = 0;
        end
        test_reset();
        test_swap_to_r800();
        test_swap_back_toggle();
        test_timeout();
        test_step();
        test_reset_in_swap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
